// File: rtl/pp_stream_pkg.sv
// pp_stream_pkg: shared streamer state encoding, default pixel sizing and width helpers.
package pp_stream_pkg;
  typedef enum logic [1:0] {IDLE, LINE, HBLANK, FGAP} stream_state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_PIX_W = DEF_DATA_WIDTH * DEF_CHANNELS;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int addr_width(input int w, input int h);
    return cnt_width(w * h);
  endfunction
endpackage

// File: rtl/pingpong_ram.sv
// pingpong_ram: two-bank simple dual-port frame memory, address {bank, pixel}, registered read.
module pingpong_ram #(
  parameter int AW = 16,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW:0]      waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW:0]      raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [0:(2**(AW+1))-1];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: ping-pong frame store with line/frame-blanked pixel streamer and drop counter.
module frame_stream_ctrl
  import pp_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IMG_WIDTH = 176,
  parameter int IMG_HEIGHT = 240,
  parameter int H_BLANK = 16,
  parameter int FRAME_GAP = 64,
  parameter int CNT_WIDTH = 8,
  localparam int PIX_W = DATA_WIDTH * CHANNELS,
  localparam int ADDR_WIDTH = addr_width(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [PIX_W-1:0]      wr_data,
  input  logic                  wr_frame_done,
  output logic                  o_de,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic [PIX_W-1:0]      o_pix,
  output logic                  busy,
  output logic                  wr_bank,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);
  localparam int BW = cnt_width(H_BLANK > FRAME_GAP ? H_BLANK : FRAME_GAP);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] FG_LAST = BW'(FRAME_GAP - 1);
  localparam logic [ADDR_WIDTH:0] NPIX = (ADDR_WIDTH + 1)'(IMG_WIDTH * IMG_HEIGHT);

  stream_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d;
  logic rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [PIX_W-1:0] ram_q;
  logic last_col, last_row;

  pingpong_ram #(.AW(ADDR_WIDTH), .PIX_W(PIX_W)) u_ram (
    .clk  (clk),
    .we   (wr_en && ({1'b0, wr_addr} < NPIX)),
    .waddr({wr_bank_q, wr_addr}),
    .wdata(wr_data),
    .raddr({rd_bank_q, pix_q}),
    .rdata(ram_q)
  );

  assign last_col = col_q == COL_LAST;
  assign last_row = row_q == ROW_LAST;

  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    blk_d = blk_q;
    pix_d = pix_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    drop_d = (wr_frame_done && state_q != IDLE && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    de_d = state_q == LINE;
    hs_d = state_q == LINE && col_q == '0;
    vs_d = state_q == LINE && col_q == '0 && row_q == '0;
    case (state_q)
      IDLE: if (wr_frame_done) begin
        state_d = LINE;
        col_d = '0;
        row_d = '0;
        pix_d = '0;
        rd_bank_d = wr_bank_q;
        wr_bank_d = !wr_bank_q;
      end
      LINE: begin
        pix_d = (last_col && last_row) ? '0 : pix_q + 1'b1;
        col_d = last_col ? '0 : col_q + 1'b1;
        blk_d = '0;
        state_d = last_col ? HBLANK : LINE;
      end
      HBLANK: begin
        blk_d = blk_q + 1'b1;
        if (blk_q == HB_LAST) begin
          blk_d = '0;
          row_d = last_row ? '0 : row_q + 1'b1;
          state_d = !last_row ? LINE : (FRAME_GAP == 0) ? IDLE : FGAP;
        end
      end
      FGAP: begin
        blk_d = blk_q + 1'b1;
        state_d = (blk_q == FG_LAST) ? IDLE : FGAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      blk_q <= '0;
      pix_q <= '0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      drop_q <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      blk_q <= blk_d;
      pix_q <= pix_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      drop_q <= drop_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign o_de = de_q;
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_pix = de_q ? ram_q : '0;
  assign busy = state_q != IDLE;
  assign wr_bank = wr_bank_q;
  assign drop_cnt = drop_q;
endmodule
